// File: rtl/key_freq_ctrl.sv
// Key-driven DDS tuning word controller: UP/DOWN with long-press auto-repeat, STEP cycles decade size.
// Optional FREQ_WRAP_EN: wrap around the limits instead of saturating.
module key_freq_ctrl #(
  parameter int unsigned          FW_WIDTH   = 32,
  parameter logic [FW_WIDTH-1:0]  FREQ_INIT  = FW_WIDTH'(1_000_000),
  parameter logic [FW_WIDTH-1:0]  FREQ_MIN   = '0,
  parameter logic [FW_WIDTH-1:0]  FREQ_MAX   = '1,
  parameter int unsigned          LONG_CYC   = 50_000_000,
  parameter int unsigned          REPEAT_CYC = 10_000_000
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                up_flag,
  input  logic                up_state,
  input  logic                dn_flag,
  input  logic                dn_state,
  input  logic                step_flag,
  input  logic                step_state,
  output logic [FW_WIDTH-1:0] freq_word,
  output logic                word_valid,
  output logic [2:0]          step_idx,
  output logic                at_limit
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int unsigned CNT_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYC - 1);

  logic [1:0]          state_q, state_d;
  logic                dir_q, dir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          step_idx_q, step_idx_d;
  logic [FW_WIDTH-1:0] freq_q, freq_d;
  logic                valid_q, valid_d;

  logic up_press, up_rel, dn_press, dn_rel, step_press, dir_rel;
  logic apply, apply_dn;

  assign up_press   = up_flag & ~up_state;
  assign up_rel     = up_flag & up_state;
  assign dn_press   = dn_flag & ~dn_state;
  assign dn_rel     = dn_flag & dn_state;
  assign step_press = step_flag & ~step_state;
  assign dir_rel    = (dir_q == DIR_DN) ? dn_rel : up_rel;

  // Decade step table 10**gi, truncated to the word width.
  logic [FW_WIDTH-1:0] step_tab [8];
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_step
      localparam int unsigned STEP_VAL = 10 ** gi;
      assign step_tab[gi] = FW_WIDTH'(STEP_VAL);
    end
  endgenerate

  logic [FW_WIDTH-1:0] step_val;
  logic [FW_WIDTH:0]   fw_ext, step_ext, min_ext, max_ext, up_sum, dn_floor;
  logic [FW_WIDTH-1:0] up_res, dn_res, new_res;
  logic                new_valid;

  assign step_val = step_tab[step_idx_q];
  assign fw_ext   = {1'b0, freq_q};
  assign step_ext = {1'b0, step_val};
  assign min_ext  = {1'b0, FREQ_MIN};
  assign max_ext  = {1'b0, FREQ_MAX};
  assign up_sum   = fw_ext + step_ext;
  assign dn_floor = min_ext + step_ext;

`ifdef FREQ_WRAP_EN
  // Overshoot past one limit re-enters from the other by the same distance.
  always_comb begin
    up_res = up_sum[FW_WIDTH-1:0];
    if (up_sum > max_ext) begin
      up_res = FW_WIDTH'(min_ext + (up_sum - max_ext - 1'b1));
    end
    dn_res = freq_q - step_val;
    if (fw_ext < dn_floor) begin
      dn_res = FW_WIDTH'(max_ext - ((dn_floor - fw_ext) - 1'b1));
    end
  end
  assign new_res   = apply_dn ? dn_res : up_res;
  assign new_valid = apply;
  assign at_limit  = 1'b0;
`else
  always_comb begin
    up_res = (up_sum > max_ext) ? FREQ_MAX : up_sum[FW_WIDTH-1:0];
    dn_res = (fw_ext < dn_floor) ? FREQ_MIN : (freq_q - step_val);
  end
  assign new_res   = apply_dn ? dn_res : up_res;
  // A saturated step that leaves the word unchanged is not announced.
  assign new_valid = apply && (new_res != freq_q);
  assign at_limit  = (freq_q == FREQ_MIN) || (freq_q == FREQ_MAX);
`endif

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    step_idx_d = step_idx_q;
    apply      = 1'b0;
    apply_dn   = dir_q;

    if (step_press) begin
      step_idx_d = step_idx_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (up_press && !dn_press) begin
          apply    = 1'b1;
          apply_dn = DIR_UP;
          dir_d    = DIR_UP;
          state_d  = HOLD;
        end else if (dn_press && !up_press) begin
          apply    = 1'b1;
          apply_dn = DIR_DN;
          dir_d    = DIR_DN;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (dir_rel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == LONG_TC) begin
          apply   = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (dir_rel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == REPEAT_TC) begin
          apply = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    freq_d  = apply ? new_res : freq_q;
    valid_d = new_valid;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= DIR_UP;
      cnt_q      <= '0;
      step_idx_q <= 3'd0;
      freq_q     <= FREQ_INIT;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      step_idx_q <= step_idx_d;
      freq_q     <= freq_d;
      valid_q    <= valid_d;
    end
  end

  assign freq_word  = freq_q;
  assign word_valid = valid_q;
  assign step_idx   = step_idx_q;

endmodule

// File: tb/tb_key_freq_ctrl.sv
// Scoreboard bench for key_freq_ctrl: stimulus queues expected word_valid pulses, a monitor checks them.
module tb_key_freq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up_flag = 1'b0, up_state = 1'b1;
  logic        dn_flag = 1'b0, dn_state = 1'b1;
  logic        step_flag = 1'b0, step_state = 1'b1;
  logic [31:0] freq_word;
  logic        word_valid;
  logic [2:0]  step_idx;
  logic        at_limit;

  key_freq_ctrl #(
    .FW_WIDTH  (32),
    .FREQ_INIT (32'd100),
    .FREQ_MIN  (32'd10),
    .FREQ_MAX  (32'd1000),
    .LONG_CYC  (20),
    .REPEAT_CYC(5)
  ) dut (
    .sys_clk   (clk),
    .rst       (rst),
    .up_flag   (up_flag),
    .up_state  (up_state),
    .dn_flag   (dn_flag),
    .dn_state  (dn_state),
    .step_flag (step_flag),
    .step_state(step_state),
    .freq_word (freq_word),
    .word_valid(word_valid),
    .step_idx  (step_idx),
    .at_limit  (at_limit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] f;
    logic        lim;
    int          c;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  localparam int K_UP = 0, K_DN = 1, K_STEP = 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every word_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (word_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual freq=%0d at cyc %0d expected no pulse", freq_word, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("pulse_cycle", cyc, mon_e.c);
        chk("pulse_freq", freq_word, mon_e.f);
        chk("pulse_at_limit", {31'd0, at_limit}, {31'd0, mon_e.lim});
        $display("txn cyc=%0d freq_word=%0d at_limit=%0b step_idx=%0d", cyc, freq_word, at_limit, step_idx);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int key, input logic st);
    case (key)
      K_UP:    begin up_flag = 1'b1;   up_state = st;   end
      K_DN:    begin dn_flag = 1'b1;   dn_state = st;   end
      default: begin step_flag = 1'b1; step_state = st; end
    endcase
    tick();
    up_flag = 1'b0;   up_state = 1'b1;
    dn_flag = 1'b0;   dn_state = 1'b1;
    step_flag = 1'b0; step_state = 1'b1;
  endtask

  task automatic expect_pulse(input logic [31:0] f, input logic lim, input int c);
    exp_t e;
    e.f = f;
    e.lim = lim;
    e.c = c;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulses actual pending=%0d expected 0 (next freq=%0d cyc=%0d)",
               name, q.size(), q[0].f, q[0].c);
    end
    q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    chk("reset_freq", freq_word, 32'd100);
    chk("reset_valid", {31'd0, word_valid}, 32'd0);
    chk("reset_step_idx", {29'd0, step_idx}, 32'd0);
    chk("reset_at_limit", {31'd0, at_limit}, 32'd0);
  endtask

  int p;

  initial begin
    // Single short UP press with step 1.
    do_reset();
    expect_pulse(32'd101, 1'b0, cyc + 1);
    pulse(K_UP, 1'b0);
    ticks(3);
    pulse(K_UP, 1'b1);
    ticks(10);
    chk("t1_freq", freq_word, 32'd101);
    drain("t1");

    // STEP twice then DN to the lower limit, then a second DN.
    do_reset();
    pulse(K_STEP, 1'b0);
    pulse(K_STEP, 1'b0);
    pulse(K_STEP, 1'b1);
    chk("t2_step_idx", {29'd0, step_idx}, 32'd2);
    chk("t2_freq_unchanged", freq_word, 32'd100);
`ifdef FREQ_WRAP_EN
    expect_pulse(32'd991, 1'b0, cyc + 1);
`else
    expect_pulse(32'd10, 1'b1, cyc + 1);
`endif
    pulse(K_DN, 1'b0);
    pulse(K_DN, 1'b1);
    ticks(2);
`ifdef FREQ_WRAP_EN
    chk("t2_at_limit", {31'd0, at_limit}, 32'd0);
    expect_pulse(32'd891, 1'b0, cyc + 1);
`else
    chk("t2_at_limit", {31'd0, at_limit}, 32'd1);
`endif
    pulse(K_DN, 1'b0);
    pulse(K_DN, 1'b1);
    ticks(5);
`ifdef FREQ_WRAP_EN
    chk("t2_freq", freq_word, 32'd891);
`else
    chk("t2_freq", freq_word, 32'd10);
`endif
    drain("t2");

    // Long UP hold, step 10: press, hold terminal, repeats, release on a terminal count.
    do_reset();
    pulse(K_STEP, 1'b0);
    p = cyc;
    expect_pulse(32'd110, 1'b0, p + 1);
    expect_pulse(32'd120, 1'b0, p + 21);
    expect_pulse(32'd130, 1'b0, p + 26);
    expect_pulse(32'd140, 1'b0, p + 31);
    expect_pulse(32'd150, 1'b0, p + 36);
    pulse(K_UP, 1'b0);
    ticks(39);
    pulse(K_UP, 1'b1);
    ticks(10);
    chk("t3_freq", freq_word, 32'd150);
    drain("t3");

    // Simultaneous UP+DN press, then opposite key during a hold.
    do_reset();
    up_flag = 1'b1; up_state = 1'b0;
    dn_flag = 1'b1; dn_state = 1'b0;
    tick();
    up_flag = 1'b0; up_state = 1'b1;
    dn_flag = 1'b0; dn_state = 1'b1;
    ticks(3);
    chk("t4_both_freq", freq_word, 32'd100);
    expect_pulse(32'd101, 1'b0, cyc + 1);
    pulse(K_UP, 1'b0);
    ticks(2);
    pulse(K_DN, 1'b0);
    pulse(K_DN, 1'b1);
    ticks(2);
    pulse(K_UP, 1'b1);
    ticks(5);
    chk("t4_freq", freq_word, 32'd101);
    drain("t4");

    // Step 1000 from 100 overshoots the upper limit.
    do_reset();
    pulse(K_STEP, 1'b0);
    pulse(K_STEP, 1'b0);
    pulse(K_STEP, 1'b0);
    chk("t5_step_idx", {29'd0, step_idx}, 32'd3);
`ifdef FREQ_WRAP_EN
    expect_pulse(32'd109, 1'b0, cyc + 1);
`else
    expect_pulse(32'd1000, 1'b1, cyc + 1);
`endif
    pulse(K_UP, 1'b0);
    pulse(K_UP, 1'b1);
    ticks(3);
`ifdef FREQ_WRAP_EN
    chk("t5_freq", freq_word, 32'd109);
    chk("t5_at_limit", {31'd0, at_limit}, 32'd0);
`else
    chk("t5_freq", freq_word, 32'd1000);
    chk("t5_at_limit", {31'd0, at_limit}, 32'd1);
`endif
    drain("t5");

    // Reset while auto-repeating aborts with no step; held key stays inert.
    do_reset();
    pulse(K_STEP, 1'b0);
    p = cyc;
    expect_pulse(32'd110, 1'b0, p + 1);
    expect_pulse(32'd120, 1'b0, p + 21);
    pulse(K_UP, 1'b0);
    ticks(22);
    rst = 1'b1;
    tick();
    chk("t6_rst_freq", freq_word, 32'd100);
    chk("t6_rst_valid", {31'd0, word_valid}, 32'd0);
    chk("t6_rst_step_idx", {29'd0, step_idx}, 32'd0);
    rst = 1'b0;
    ticks(30);
    chk("t6_freq_after", freq_word, 32'd100);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
